cart_bus_arbiter: RTL and testbench

Shares the external cartridge bus (address, bidirectional data, rd/wr/cs strobes) between two requesters: the Game Boy core (requester 0) and the UART debug/loader engine (requester 1, peek/poke of cartridge ROM/RAM while the core is halted or idle). The block sequences each access as setup, strobe and hold phases with programmable widths. It drives the pad-side strobes active-high; top-level inversion to the active-low pins is unchanged.

---
 rtl/cart_bus_pkg.sv | 20 ++
 rtl/rst_sync.sv | 23 ++
 rtl/cart_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_cart_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus arbiter.
package cart_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } cb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } cb_owner_e;

  localparam logic [15:0] CS_LO = 16'hA000;
  localparam logic [15:0] CS_HI = 16'hFDFF;

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases two clocks after rst_n rises.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst_n
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rst_n = r_sync;

endmodule

// File: rtl/cart_bus_arbiter.sv
// Two-requester cartridge bus arbiter with setup/strobe/hold sequencing.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed core priority.
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int AW         = 16,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] bus_a,
  output logic [DW-1:0] bus_dout,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_din,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic          bus_cs,
  output logic          busy
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  logic          w_rst_n;
  cb_state_e     r_state;
  logic [3:0]    r_cnt;
  cb_owner_e     r_own;
  logic          r_we;
  logic          w_c_pend;
  logic          w_d_pend;
  cb_owner_e     w_gnt;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_cs;

  rst_sync u_rst_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_rst_n (w_rst_n)
  );

  // A requester whose ack is on this cycle is still holding req; don't re-grant it.
  assign w_c_pend = c_req & ~c_ack;
  assign w_d_pend = d_req & ~d_ack;

`ifdef ARB_RR_EN
  cb_owner_e r_last;
  always_comb begin
    w_gnt = OWN_CORE;
    if (w_d_pend && (!w_c_pend || r_last == OWN_CORE)) w_gnt = OWN_DBG;
  end
`else
  assign w_gnt = w_c_pend ? OWN_CORE : OWN_DBG;
`endif

  assign w_we    = (w_gnt == OWN_DBG) ? d_we    : c_we;
  assign w_addr  = (w_gnt == OWN_DBG) ? d_addr  : c_addr;
  assign w_wdata = (w_gnt == OWN_DBG) ? d_wdata : c_wdata;
  assign w_cs    = (32'(w_addr) >= 32'(CS_LO)) && (32'(w_addr) <= 32'(CS_HI));

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_own    <= OWN_CORE;
      r_we     <= 1'b0;
      bus_a    <= '0;
      bus_dout <= '0;
      bus_oe   <= 1'b0;
      bus_rd   <= 1'b0;
      bus_wr   <= 1'b0;
      bus_cs   <= 1'b0;
      c_ack    <= 1'b0;
      d_ack    <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_c_pend || w_d_pend) begin
            r_own    <= w_gnt;
            r_we     <= w_we;
            bus_a    <= w_addr;
            bus_dout <= w_wdata;
            bus_oe   <= w_we;
            bus_cs   <= w_cs;
            r_cnt    <= SETUP_LD;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == 4'd0) begin
            bus_rd  <= ~r_we;
            bus_wr  <= r_we;
            r_cnt   <= STROBE_LD;
            r_state <= STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            if (!r_we) begin
              if (r_own == OWN_DBG) d_rdata <= bus_din;
              else                  c_rdata <= bus_din;
            end
            r_cnt   <= HOLD_LD;
            r_state <= (HOLD_CYC == 0) ? DONE : HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (r_cnt == 4'd0) r_state <= DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        DONE: begin
          c_ack   <= (r_own == OWN_CORE);
          d_ack   <= (r_own == OWN_DBG);
          bus_oe  <= 1'b0;
          bus_cs  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                                     r_last <= OWN_DBG;
    else if (r_state == IDLE && (w_c_pend || w_d_pend)) r_last <= w_gnt;
  end
`endif

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: default timing instance plus a 1/1/0 fast instance.
module tb_cart_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we, f_c_req, f_d_req;
  logic [15:0] c_addr, d_addr;
  logic [7:0]  c_wdata, d_wdata, bus_din;

  logic        c_ack, d_ack, bus_oe, bus_rd, bus_wr, bus_cs, busy;
  logic [7:0]  c_rdata, d_rdata, bus_dout;
  logic [15:0] bus_a;

  logic        f_c_ack, f_d_ack, f_oe, f_rd, f_wr, f_cs, f_busy;
  logic [7:0]  f_c_rdata, f_d_rdata, f_dout;
  logic [15:0] f_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cart_bus_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_cs(bus_cs), .busy(busy)
  );

  cart_bus_arbiter #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .c_req(f_c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(f_c_ack), .c_rdata(f_c_rdata),
    .d_req(f_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(f_d_ack), .d_rdata(f_d_rdata),
    .bus_a(f_a), .bus_dout(f_dout), .bus_oe(f_oe), .bus_din(bus_din),
    .bus_rd(f_rd), .bus_wr(f_wr), .bus_cs(f_cs), .busy(f_busy)
  );

  // Advance one cycle, land on the falling edge, and check the strobe invariants.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ((bus_rd & bus_wr) !== 1'b0 || (f_rd & f_wr) !== 1'b0) begin
      errors++;
      $display("FAIL rd_wr_excl t=%0t rd=%b wr=%b frd=%b fwr=%b required no overlap", $time, bus_rd, bus_wr, f_rd, f_wr);
    end
    checks++;
    if ((bus_oe & bus_rd) !== 1'b0 || (f_oe & f_rd) !== 1'b0) begin
      errors++;
      $display("FAIL oe_rd_excl t=%0t oe=%b rd=%b foe=%b frd=%b required no overlap", $time, bus_oe, bus_rd, f_oe, f_rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_c_req = 0; f_d_req = 0; bus_din = '0;
    tick(); tick();
    checks++;
    if ({bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, c_ack, d_ack, c_rdata, d_rdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h dout=%h oe=%b rd=%b wr=%b cs=%b ca=%b da=%b busy=%b required all 0",
               bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, c_ack, d_ack, busy);
    end
    checks++;
    if ({f_a, f_oe, f_rd, f_wr, f_cs, f_c_ack, f_busy} !== '0) begin
      errors++;
      $display("FAIL reset_fast got a=%h oe=%b rd=%b busy=%b required 0", f_a, f_oe, f_rd, f_busy);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_core_read();
    logic e_rd, e_ack;
    c_we = 0; c_addr = 16'h0150; bus_din = 8'h3C; c_req = 1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_rd  = (t >= 2 && t <= 5);
      e_ack = (t == 8);
      checks++;
      if (bus_rd !== e_rd) begin
        errors++; $display("FAIL core_rd_strobe cycle %0d got %b required %b", t, bus_rd, e_rd);
      end
      checks++;
      if (c_ack !== e_ack) begin
        errors++; $display("FAIL core_rd_ack cycle %0d got %b required %b", t, c_ack, e_ack);
      end
      checks++;
      if (bus_cs !== 1'b0) begin
        errors++; $display("FAIL core_rd_cs cycle %0d got %b required 0", t, bus_cs);
      end
      if (t == 8) c_req = 0;
    end
    checks++;
    if (c_rdata !== 8'h3C || bus_a !== 16'h0150) begin
      errors++; $display("FAIL core_rd_data got rdata=%h a=%h required 3c/0150", c_rdata, bus_a);
    end
    tick();
    checks++;
    if (c_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL core_rd_after got ack=%b busy=%b required 0/0", c_ack, busy);
    end
  endtask

  task automatic test_dbg_write();
    logic e_wr, e_ack;
    d_we = 1; d_addr = 16'hA000; d_wdata = 8'h5A; d_req = 1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e_wr  = (t >= 2 && t <= 5);
      e_ack = (t == 8);
      checks++;
      if (bus_wr !== e_wr) begin
        errors++; $display("FAIL dbg_wr_strobe cycle %0d got %b required %b", t, bus_wr, e_wr);
      end
      if (t <= 6) begin
        checks++;
        if (bus_oe !== 1'b1 || bus_cs !== 1'b1 || bus_dout !== 8'h5A) begin
          errors++; $display("FAIL dbg_wr_drive cycle %0d got oe=%b cs=%b dout=%h required 1/1/5a", t, bus_oe, bus_cs, bus_dout);
        end
      end
      checks++;
      if (d_ack !== e_ack || c_ack !== 1'b0) begin
        errors++; $display("FAIL dbg_wr_ack cycle %0d got d=%b c=%b required %b/0", t, d_ack, c_ack, e_ack);
      end
      if (t == 8) d_req = 0;
    end
    checks++;
    if (bus_oe !== 1'b0 || bus_cs !== 1'b0) begin
      errors++; $display("FAIL dbg_wr_release got oe=%b cs=%b required 0/0", bus_oe, bus_cs);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    c_we = 0; c_addr = 16'h0200; d_we = 0; d_addr = 16'h8000; bus_din = 8'h11;
    c_req = 1; d_req = 1;
    n = 0;
    while (c_ack !== 1'b1 && n < 20) begin tick(); n++; end
    c_req = 0;
    checks++;
    if (n != 8 || d_ack !== 1'b0) begin
      errors++; $display("FAIL tie_core_first core ack after %0d cycles d_ack=%b required 8/0", n, d_ack);
    end
    n = 0;
    while (d_ack !== 1'b1 && n < 20) begin
      tick(); n++;
      if (n == 1) begin
        checks++;
        if (bus_a !== 16'h8000) begin
          errors++; $display("FAIL tie_dbg_addr got %h required 8000", bus_a);
        end
      end
    end
    d_req = 0;
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL tie_dbg_next dbg ack %0d cycles after core ack required 8", n);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    d_we = 1; d_addr = 16'hB000; d_wdata = 8'h5A; d_req = 1;
    tick(); tick(); tick();
    checks++;
    if (bus_wr !== 1'b1 || bus_oe !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got wr=%b oe=%b required 1/1", bus_wr, bus_oe);
    end
    rst_n = 1'b0; d_req = 0;
    #1;
    checks++;
    if (bus_wr !== 1'b0 || bus_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async got wr=%b oe=%b busy=%b required 0/0/0", bus_wr, bus_oe, busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 10; t++) begin tick(); if (d_ack === 1'b1) n++; end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL rst_mid_noack got %0d acks required 0", n);
    end
    c_we = 1; c_addr = 16'hC000; c_wdata = 8'h99; c_req = 1;
    n = 0;
    while (c_ack !== 1'b1 && n < 20) begin tick(); n++; end
    c_req = 0;
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL rst_mid_fresh ack after %0d cycles required 8", n);
    end
    tick();
  endtask

  task automatic test_short_timing();
    int n;
    int rd_cnt;
    c_we = 0; c_addr = 16'h0100; bus_din = 8'h42; f_c_req = 1;
    n = 0; rd_cnt = 0;
    while (f_c_ack !== 1'b1 && n < 20) begin tick(); n++; if (f_rd === 1'b1) rd_cnt++; end
    f_c_req = 0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL short_latency ack after %0d cycles required 4", n);
    end
    checks++;
    if (rd_cnt != 1 || f_c_rdata !== 8'h42) begin
      errors++; $display("FAIL short_read rd cycles %0d rdata %h required 1/42", rd_cnt, f_c_rdata);
    end
    tick();
  endtask

  task automatic test_req_drop();
    int n;
    d_we = 0; d_addr = 16'h4000; bus_din = 8'h77; d_req = 1;
    tick();
    d_req = 0;
    n = 1;
    while (d_ack !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != 8 || d_rdata !== 8'h77) begin
      errors++; $display("FAIL drop_ack ack after %0d cycles rdata %h required 8/77", n, d_rdata);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || d_ack !== 1'b0) begin
        errors++; $display("FAIL drop_no_second cycle %0d busy=%b ack=%b required 0/0", t, busy, d_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dbg_write();
    test_back_to_back();
    test_reset_mid();
    test_short_timing();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
